dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters, one access per clock.
- Port 0 is the processor's data interface; port 1 is an auxiliary master (loader/DMA/debug).
- Sits between the processor/aux master and the data memory.
- Provides fixed priority to port 0, a starvation guard for port 1, locked bursts for port 1, and registered read-data return.

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- MAX_WAIT, 4, consecutive cycles port 1 may wait unserved before it wins priority.
- MAX_BURST, 8, maximum consecutive locked beats granted to port 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_req  input  1  port 0 access request.
- m0_we  input  1  port 0 write enable (1 = write).
- m0_addr  input  AW  port 0 byte address.
- m0_wdata  input  DW  port 0 write data.
- m0_gnt  output  1  port 0 access performed this cycle.
- m0_rvalid  output  1  port 0 read data valid (one cycle after the read grant).
- m0_rdata  output  DW  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata  input  1/1/AW/DW  port 1 request fields, same meaning as port 0.
- m1_lock  input  1  port 1 requests that ownership continue next cycle (burst).
- m1_gnt, m1_rvalid, m1_rdata  output  1/1/DW  port 1 responses, same meaning as port 0.
- cpu_stall  output  1  m0_req & ~m0_gnt; processor holds its PC.
- mem_we  output  1  memory write strobe.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory combinational read data.

Behaviour:
- Memory model: combinational read, write on the clk edge when mem_we=1.
- Grant: m0_gnt and m1_gnt are combinational from req, FSM state and wait counter. At most one is 1 per cycle.
- Memory drive:
  - The granted port drives mem_addr and mem_wdata.
  - mem_we = gnt & we of that port.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - When a read is granted, mem_rdata is registered into mx_rdata.
  - mx_rvalid=1 on the next cycle for exactly one cycle.
  - mx_rdata holds its value until the next read to that port.
  - Writes never raise rvalid.
- FSM states: IDLE, OWN0, OWN1, BURST1.
  - IDLE/OWN0/OWN1, priority order:
    - (a) m1_req and wait_cnt==MAX_WAIT -> grant port 1.
    - (b) else m0_req -> grant port 0.
    - (c) else m1_req -> grant port 1.
    - (d) else no grant, next state IDLE.
  - Next state: OWN0 after a port 0 grant; after a port 1 grant, BURST1 if m1_lock=1, else OWN1.
  - BURST1:
    - Port 1 is granted exclusively if m1_req=1; m0 is stalled.
    - burst_cnt increments per beat.
    - Exit to OWN1 when m1_lock=0, m1_req=0, or burst_cnt reaches MAX_BURST-1 (the last beat is granted).
    - On exit via m1_req=0, no grant is issued that cycle.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle m1_req=1 and m1_gnt=0.
  - Clears on m1_gnt or when m1_req=0.
- burst_cnt: clears on entry to BURST1 and on exit.
- Simultaneous m0/m1 requests with wait_cnt<MAX_WAIT: port 0 wins.
- Requesters hold req and fields stable until gnt.
- Reset (reset=0), asynchronous:
  - State IDLE, wait_cnt=0, burst_cnt=0.
  - m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0.
  - Combinational outputs follow (no grant while in reset).
- Reset mid-burst or with a read in flight: the pending rvalid is dropped and not replayed.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef enum arb_state_t {IDLE, OWN0, OWN1, BURST1};
  - constants DW, AW defaults;
  - typedef of the request bundle (req, we, addr, wdata).
- One sub-module, rd_return_reg: the per-port rvalid/rdata register, instantiated twice.

Test Plan:
- Reset then m0 read addr 0x10, mem holds 0xDEADBEEF -> m0_gnt=1 same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; cpu_stall=0.
- m0 and m1 request continuously -> m0 granted 4 cycles, m1 granted on the 5th (wait_cnt=4), then m0 resumes; cpu_stall=1 only on the m1 cycle.
- m1 write burst of 8 beats, m1_lock=1 throughout, m0_req=1 -> 8 consecutive m1 grants, mem_we=1 each beat; 9th cycle m0_gnt=1.
- m1 drops m1_lock after beat 3 -> FSM leaves BURST1 after beat 3; m0 is granted next cycle.
- No requests -> mem_we=0, mem_addr=0, both gnt=0, state IDLE.
- Assert reset one cycle after an m1 read grant -> m1_rvalid stays 0, state IDLE, counters 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: arbiter state encoding, default bus widths, request bundle type,
// and a counter-width helper.
package dmem_pkg;

    localparam int DMEM_DW = 32;
    localparam int DMEM_AW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN0   = 2'd1,
        OWN1   = 2'd2,
        BURST1 = 2'd3
    } arb_state_t;

    // One requester's access fields. Sized by the package defaults; a build
    // with non-default DW/AW must change DMEM_DW/DMEM_AW to match.
    typedef struct packed {
        logic               req;
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
    } dmem_req_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rd_return_reg.sv
// Per-port read-return register: captures memory read data for one requester.
// Latency: rvalid/rdata appear one cycle after the captured read grant.
// Backpressure: none; the requester must accept rvalid when it is asserted.
//
// Ports: clk, reset (async active-low), capture (read granted this cycle),
//        din (combinational memory read data), rvalid (one-cycle pulse),
//        rdata (held until the next captured read).
module rd_return_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          capture,
    input  logic [DW-1:0] din,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= capture;
            if (capture) begin
                rdata <= din;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single data-memory port: port 0 (CPU) has fixed
// priority, port 1 (aux master) gets a starvation guard and locked bursts.
// Latency: grant and memory drive are combinational; read data returns one
// cycle after the grant. Backpressure: an ungranted requester holds its
// request; cpu_stall tells the processor to hold its PC.
//
// Ports: clk, reset (async active-low); m0_* / m1_* requester interfaces
//        (req/we/addr/wdata in, gnt/rvalid/rdata out, m1_lock for bursts);
//        cpu_stall; mem_we/mem_addr/mem_wdata out, mem_rdata in.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DW        = DMEM_DW,
    parameter int AW        = DMEM_AW,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          cpu_stall,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WAIT_W  = cnt_w(MAX_WAIT + 1);
    localparam int BURST_W = cnt_w(MAX_BURST);

    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MAX_WAIT);
    // The beat that enters BURST1 is granted from OWN*/IDLE, so inside BURST1
    // the beat number is burst_cnt+2; the last allowed beat is MAX_BURST.
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 2);
    localparam bit                 BURST_OK   = (MAX_BURST > 1);

    dmem_req_t  p0;
    dmem_req_t  p1;

    arb_state_t          state;
    arb_state_t          next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [BURST_W-1:0]  burst_cnt;
    logic                gnt0;
    logic                gnt1;
    logic                starved;
    logic                burst_end;

    assign p0 = '{req: m0_req, we: m0_we, addr: m0_addr, wdata: m0_wdata};
    assign p1 = '{req: m1_req, we: m1_we, addr: m1_addr, wdata: m1_wdata};

    assign starved   = p1.req && (wait_cnt == WAIT_MAX);
    assign burst_end = (burst_cnt == BURST_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = IDLE;
        case (state)
            BURST1: begin
                // Any of: requester gone, lock dropped, or burst limit hit
                // ends the burst; ownership falls back to OWN1.
                if (p1.req && m1_lock && !burst_end) begin
                    next_state = BURST1;
                end else begin
                    next_state = OWN1;
                end
            end
            default: begin
                if (gnt1) begin
                    next_state = (m1_lock && BURST_OK) ? BURST1 : OWN1;
                end else if (gnt0) begin
                    next_state = OWN0;
                end else begin
                    next_state = IDLE;
                end
            end
        endcase
    end

    // ---------------- output logic: grants and memory drive ----------------
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // No grants are issued while reset is held.
        if (reset) begin
            if (state == BURST1) begin
                gnt1 = p1.req;
            end else if (starved) begin
                gnt1 = 1'b1;
            end else if (p0.req) begin
                gnt0 = 1'b1;
            end else if (p1.req) begin
                gnt1 = 1'b1;
            end
        end

        if (gnt0) begin
            mem_we    = p0.we;
            mem_addr  = p0.addr;
            mem_wdata = p0.wdata;
        end else if (gnt1) begin
            mem_we    = p1.we;
            mem_addr  = p1.addr;
            mem_wdata = p1.wdata;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign cpu_stall = m0_req & ~gnt0;

    // ---------------- starvation counter ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!p1.req || gnt1) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // ---------------- burst beat counter ----------------
    // Zero on entry to BURST1 (it is zero outside the burst) and on exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else if (state == BURST1 && next_state == BURST1) begin
            burst_cnt <= burst_cnt + 1'b1;
        end else begin
            burst_cnt <= '0;
        end
    end

    // ---------------- read return ----------------
    rd_return_reg #(.DW(DW)) u_rd0 (
        .clk     (clk),
        .reset   (reset),
        .capture (gnt0 & ~p0.we),
        .din     (mem_rdata),
        .rvalid  (m0_rvalid),
        .rdata   (m0_rdata)
    );

    rd_return_reg #(.DW(DW)) u_rd1 (
        .clk     (clk),
        .reset   (reset),
        .capture (gnt1 & ~p1.we),
        .din     (mem_rdata),
        .rvalid  (m1_rvalid),
        .rdata   (m1_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          cpu_stall, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .cpu_stall(cpu_stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment memory: combinational read, write on the clock edge.
    logic [31:0] env_mem [64];
    assign mem_rdata = env_mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) env_mem[mem_addr[7:2]] <= mem_wdata;

    // ---------------- reference model ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [64];
    int          waited;        // cycles port 1 has gone unserved
    bit          in_burst;      // inside a locked port-1 run
    int          beats;         // grants so far in the locked run
    bit          exp_g0, exp_g1, exp_rv0, exp_rv1;
    logic [31:0] exp_rd0, exp_rd1;
    bit          act_g0, act_g1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        waited = 0; in_burst = 0; beats = 0;
        exp_rv0 = 0; exp_rv1 = 0; exp_rd0 = '0; exp_rd1 = '0;
    endtask

    task automatic model_grant();
        exp_g0 = 0; exp_g1 = 0;
        if (reset) begin
            if (in_burst)                          exp_g1 = m1_req;
            else if (m1_req && waited >= MAX_WAIT) exp_g1 = 1;
            else if (m0_req)                       exp_g0 = 1;
            else if (m1_req)                       exp_g1 = 1;
        end
    endtask

    task automatic check_cycle();
        logic        e_we;
        logic [31:0] e_addr, e_wdata;
        #3;
        model_grant();
        act_g0 = m0_gnt;
        act_g1 = m1_gnt;
        e_we = 0; e_addr = '0; e_wdata = '0;
        if (exp_g0)      begin e_we = m0_we; e_addr = m0_addr; e_wdata = m0_wdata; end
        else if (exp_g1) begin e_we = m1_we; e_addr = m1_addr; e_wdata = m1_wdata; end
        chk("m0_gnt", m0_gnt, exp_g0);
        chk("m1_gnt", m1_gnt, exp_g1);
        chk("cpu_stall", cpu_stall, m0_req & ~exp_g0);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("m0_rvalid", m0_rvalid, exp_rv0);
        chk("m1_rvalid", m1_rvalid, exp_rv1);
        chk("m0_rdata", m0_rdata, exp_rd0);
        chk("m1_rdata", m1_rdata, exp_rd1);
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
            return;
        end
        exp_rv0 = exp_g0 && !m0_we;
        exp_rv1 = exp_g1 && !m1_we;
        if (exp_g0) begin
            if (m0_we) ref_mem[m0_addr[7:2]] = m0_wdata;
            else       exp_rd0 = ref_mem[m0_addr[7:2]];
        end
        if (exp_g1) begin
            if (m1_we) ref_mem[m1_addr[7:2]] = m1_wdata;
            else       exp_rd1 = ref_mem[m1_addr[7:2]];
        end
        if (exp_g1 || !m1_req) waited = 0;
        else if (waited < MAX_WAIT) waited++;
        if (in_burst) begin
            if (exp_g1) beats++;
            if (!m1_req || !m1_lock || beats >= MAX_BURST) begin
                in_burst = 0; beats = 0;
            end
        end else if (exp_g1 && m1_lock && MAX_BURST > 1) begin
            in_burst = 1; beats = 1;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick();
        check_cycle();
        advance();
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] seq0, seq1, seqs;
    int         run, n1;
    bit         we_all, m0_after;

    initial begin
        reset = 0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
        model_reset();
        for (int i = 0; i < 64; i++) begin
            logic [31:0] v;
            v = $urandom;
            env_mem[i] <= v;
            ref_mem[i] = v;
        end
        env_mem[4] <= 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        // Reset: a pending request must not be granted while reset is low.
        m0_req = 1; m0_addr = 32'h10;
        check_cycle();
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_state", dut.state, IDLE);
        advance();
        reset = 1;

        // Test 1: single port-0 read.
        check_cycle();
        chk("t1_gnt", m0_gnt, 1);
        chk("t1_stall", cpu_stall, 0);
        advance();
        m0_req = 0;
        check_cycle();
        chk("t1_rvalid", m0_rvalid, 1);
        chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
        advance();

        // Test 2: both ports request continuously; starvation guard.
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        m1_req = 1; m1_we = 0; m1_addr = 32'h30; m1_lock = 0;
        for (int i = 0; i < 6; i++) begin
            check_cycle();
            seq0[i] = act_g0; seq1[i] = act_g1; seqs[i] = cpu_stall;
            advance();
            if (act_g1) m1_req = 0;
        end
        chk("t2_g0_seq", seq0, 6'b101111);
        chk("t2_g1_seq", seq1, 6'b010000);
        chk("t2_stall_seq", seqs, 6'b010000);
        m0_req = 0;
        tick();

        // Test 3: locked port-1 write burst against a busy port 0.
        m0_req = 1; m0_we = 0; m0_addr = 32'h40;
        m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h80; m1_wdata = $urandom;
        run = 0; we_all = 1; m0_after = 0;
        for (int i = 0; i < 40; i++) begin
            check_cycle();
            if (act_g1) begin run++; we_all &= mem_we; end
            if (act_g0 && run > 0) begin m0_after = 1; advance(); break; end
            advance();
            if (act_g1) begin m1_addr += 4; m1_wdata = $urandom; end
        end
        chk("t3_burst_len", run, MAX_BURST);
        chk("t3_we_each_beat", we_all, 1);
        chk("t3_m0_after", m0_after, 1);
        m0_req = 0; m1_lock = 0;
        tick();
        m1_req = 0;
        tick();

        // Test 4: lock dropped for beat 3 ends the burst after that beat.
        m0_req = 1; m0_we = 0; m0_addr = 32'h44;
        m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 32'hC0;
        n1 = 0; m0_after = 0;
        for (int i = 0; i < 40; i++) begin
            check_cycle();
            if (act_g1) n1++;
            if (act_g0 && n1 > 0) begin m0_after = 1; advance(); break; end
            advance();
            if (act_g1) begin
                m1_addr += 4;
                if (n1 == 2) m1_lock = 0;
            end
        end
        chk("t4_beats", n1, 3);
        chk("t4_m0_after", m0_after, 1);
        m0_req = 0;
        tick();
        m1_req = 0;
        tick();

        // Test 5: idle bus.
        tick();
        check_cycle();
        chk("t5_mem_we", mem_we, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_gnt", {m0_gnt, m1_gnt}, 2'b00);
        chk("t5_state", dut.state, IDLE);
        advance();

        // Test 6: reset right after a port-1 read grant drops the return.
        m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 32'h14;
        check_cycle();
        chk("t6_gnt", m1_gnt, 1);
        reset = 0;
        advance();
        m1_req = 0; m1_lock = 0;
        check_cycle();
        chk("t6_rvalid", m1_rvalid, 0);
        chk("t6_rdata", m1_rdata, 0);
        chk("t6_state", dut.state, IDLE);
        chk("t6_wait", dut.wait_cnt, 0);
        chk("t6_burst", dut.burst_cnt, 0);
        advance();
        reset = 1;
        tick();

        // Random traffic obeying the hold-until-granted protocol.
        for (int c = 0; c < 1500; c++) begin
            if (!m0_req && $urandom_range(0, 3) != 0) begin
                m0_req = 1; m0_we = 1'($urandom_range(0, 1));
                m0_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                m0_wdata = $urandom;
            end
            if (!m1_req && $urandom_range(0, 1) != 0) begin
                m1_req = 1; m1_we = 1'($urandom_range(0, 1));
                m1_lock = ($urandom_range(0, 2) != 0);
                m1_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                m1_wdata = $urandom;
            end
            check_cycle();
            advance();
            if (exp_g0) m0_req = 0;
            if (exp_g1) m1_req = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
